// File: rtl/stride_detector_if.sv
// Observation and stride-result bundle between the AR-channel snooper and stride_detector.
interface stride_detector_if #(
    parameter int unsigned ADDR_BITS = 64,
    parameter int unsigned TID_WIDTH = 4,
    parameter int unsigned CONF_BITS = 2
);
    logic                 obs_valid;
    logic [ADDR_BITS-1:0] obs_addr;
    logic [TID_WIDTH-1:0] obs_id;

    logic                 stride_valid;
    logic [ADDR_BITS-1:0] stride;
    logic [ADDR_BITS-1:0] pred_addr;
    logic [TID_WIDTH-1:0] track_id;
    logic [CONF_BITS-1:0] conf;

    // Observer side: presents completed AR handshakes, consumes the prediction.
    modport master (
        output obs_valid, obs_addr, obs_id,
        input  stride_valid, stride, pred_addr, track_id, conf
    );

    // Detector side.
    modport slave (
        input  obs_valid, obs_addr, obs_id,
        output stride_valid, stride, pred_addr, track_id, conf
    );
endinterface

// File: rtl/stride_detector.sv
// Trains on one AXI read ID's address stream and locks onto a constant stride.
// Define STRIDE_NEG_STRIDE_EN to accept negative (descending) strides.
module stride_detector #(
    parameter int unsigned ADDR_BITS   = 64,
    parameter int unsigned TID_WIDTH   = 4,
    parameter int unsigned CONF_BITS   = 2,
    parameter int unsigned CONF_THRESH = 2
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             en,
    input  logic             flush,
    stride_detector_if.slave bus
);

`ifdef STRIDE_NEG_STRIDE_EN
    localparam bit NEG_OK = 1'b1;
`else
    localparam bit NEG_OK = 1'b0;
`endif

    localparam logic [CONF_BITS-1:0] CONF_MAX  = '1;
    localparam logic [CONF_BITS-1:0] CONF_LOCK = CONF_BITS'(CONF_THRESH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        TRAIN  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] last_q, last_d;
    logic [ADDR_BITS-1:0] stride_q, stride_d;
    logic [ADDR_BITS-1:0] pred_q, pred_d;
    logic [TID_WIDTH-1:0] tid_q, tid_d;
    logic [CONF_BITS-1:0] conf_q, conf_d;
    logic                 valid_q, valid_d;

    logic [ADDR_BITS-1:0] delta;
    logic                 delta_ok;
    logic                 stride_hit;
    logic [CONF_BITS-1:0] conf_inc;

    // Next-state and next-output decode for one observation per cycle.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        stride_d   = stride_q;
        tid_d      = tid_q;
        conf_d     = conf_q;
        delta      = bus.obs_addr - last_q;
        delta_ok   = (delta != '0) && (NEG_OK || !delta[ADDR_BITS-1]);
        stride_hit = (delta == stride_q);
        conf_inc   = conf_q + CONF_BITS'(1);

        if (flush) begin
            state_d  = IDLE;
            last_d   = '0;
            stride_d = '0;
            tid_d    = '0;
            conf_d   = '0;
        end else if (en && bus.obs_valid) begin
            if (state_q == IDLE) begin
                state_d  = FIRST;
                last_d   = bus.obs_addr;
                tid_d    = bus.obs_id;
                stride_d = '0;
                conf_d   = '0;
            end else if (bus.obs_id == tid_q) begin
                last_d = bus.obs_addr;
                case (state_q)
                    FIRST: begin
                        if (delta_ok) begin
                            state_d  = TRAIN;
                            stride_d = delta;
                            conf_d   = '0;
                        end
                    end
                    TRAIN: begin
                        if (stride_hit) begin
                            conf_d = conf_inc;
                            if (conf_inc >= CONF_LOCK) begin
                                state_d = LOCKED;
                            end
                        end else if (delta_ok) begin
                            stride_d = delta;
                            conf_d   = '0;
                        end else begin
                            // Training restarts from the new address with no stride.
                            state_d  = FIRST;
                            stride_d = '0;
                            conf_d   = '0;
                        end
                    end
                    LOCKED: begin
                        if (stride_hit) begin
                            if (conf_q != CONF_MAX) begin
                                conf_d = conf_inc;
                            end
                        end else if (conf_q != '0) begin
                            conf_d = conf_q - CONF_BITS'(1);
                        end else if (delta_ok) begin
                            state_d  = TRAIN;
                            stride_d = delta;
                            conf_d   = '0;
                        end else begin
                            state_d  = FIRST;
                            stride_d = '0;
                            conf_d   = '0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        pred_d  = last_d + stride_d;
        valid_d = (state_d == LOCKED);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            last_q   <= '0;
            stride_q <= '0;
            pred_q   <= '0;
            tid_q    <= '0;
            conf_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            stride_q <= stride_d;
            pred_q   <= pred_d;
            tid_q    <= tid_d;
            conf_q   <= conf_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.stride_valid = valid_q;
    assign bus.stride       = stride_q;
    assign bus.pred_addr    = pred_q;
    assign bus.track_id     = tid_q;
    assign bus.conf         = conf_q;

endmodule

// File: tb/tb_stride_detector.sv
// Self-checking bench for stride_detector: directed vector table, async-reset check,
// then randomized streams against a reference model (ADDR_BITS=32, CONF_BITS=2, CONF_THRESH=2).
module tb_stride_detector;

    typedef struct {
        bit          en;
        bit          fl;
        bit          v;
        logic [31:0] addr;
        logic [3:0]  id;
        bit          sv;
        logic [31:0] stride;
        logic [31:0] pred;
        logic [3:0]  tid;
        logic [1:0]  conf;
    } vec_t;

    bit   clk;
    logic resetN;
    logic en;
    logic flush;
    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];

    stride_detector_if #(.ADDR_BITS(32), .TID_WIDTH(4), .CONF_BITS(2)) bus ();

    stride_detector #(
        .ADDR_BITS(32), .TID_WIDTH(4), .CONF_BITS(2), .CONF_THRESH(2)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .en     (en),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model state, phrased as the tracker's training stage.
    int          m_stage;
    logic [31:0] m_last;
    logic [31:0] m_stride;
    logic [3:0]  m_tid;
    int          m_conf;

`ifdef STRIDE_NEG_STRIDE_EN
    localparam bit NEG = 1'b1;
`else
    localparam bit NEG = 1'b0;
`endif

    function automatic bit legal(input logic [31:0] d);
        return ($signed(d) > 0) || (NEG && d != 32'd0);
    endfunction

    task automatic m_clear();
        m_stage = 0; m_last = '0; m_stride = '0; m_tid = '0; m_conf = 0;
    endtask

    task automatic m_restart();
        m_stage = 1; m_stride = '0; m_conf = 0;
    endtask

    task automatic m_apply(input bit e, input bit f, input bit v,
                           input logic [31:0] a, input logic [3:0] id);
        logic [31:0] d;
        if (f) begin
            m_clear();
        end else if (e && v) begin
            if (m_stage == 0) begin
                m_stage = 1; m_last = a; m_tid = id; m_stride = '0; m_conf = 0;
            end else if (id == m_tid) begin
                d      = a - m_last;
                m_last = a;
                if (m_stage == 1) begin
                    if (legal(d)) begin m_stage = 2; m_stride = d; m_conf = 0; end
                end else if (m_stage == 2) begin
                    if (d == m_stride) begin
                        m_conf++;
                        if (m_conf >= 2) m_stage = 3;
                    end else if (legal(d)) begin
                        m_stride = d; m_conf = 0;
                    end else begin
                        m_restart();
                    end
                end else begin
                    if (d == m_stride) m_conf = (m_conf < 3) ? m_conf + 1 : 3;
                    else if (m_conf > 0) m_conf--;
                    else if (legal(d)) begin m_stage = 2; m_stride = d; m_conf = 0; end
                    else m_restart();
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit sv, input logic [31:0] s,
                           input logic [31:0] p, input logic [3:0] t, input logic [1:0] c);
        chk({tag, ".stride_valid"}, 32'(bus.stride_valid), 32'(sv));
        chk({tag, ".stride"},       bus.stride,            s);
        chk({tag, ".pred_addr"},    bus.pred_addr,         p);
        chk({tag, ".track_id"},     32'(bus.track_id),     32'(t));
        chk({tag, ".conf"},         32'(bus.conf),         32'(c));
    endtask

    task automatic add(input bit e, input bit f, input bit v, input logic [31:0] a,
                       input logic [3:0] id, input bit sv, input logic [31:0] s,
                       input logic [31:0] p, input logic [3:0] t, input logic [1:0] c);
        vec_t r;
        r.en = e; r.fl = f; r.v = v; r.addr = a; r.id = id;
        r.sv = sv; r.stride = s; r.pred = p; r.tid = t; r.conf = c;
        tbl.push_back(r);
    endtask

    task automatic drive(input bit e, input bit f, input bit v,
                         input logic [31:0] a, input logic [3:0] id);
        @(negedge clk);
        en = e; flush = f; bus.obs_valid = v; bus.obs_addr = a; bus.obs_id = id;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] base [3];
        logic [31:0] step [3];
        bit          e, f, v;
        logic [31:0] a;
        logic [3:0]  id;

        n_cmp = 0; n_bad = 0;
        resetN = 1'b0; en = 1'b0; flush = 1'b0;
        bus.obs_valid = 1'b0; bus.obs_addr = '0; bus.obs_id = '0;

        // Ascending lock on id 3, foreign id, decay, retrain, saturation, flush.
        add(1,0,1,32'h1000,3, 0,32'h0,   32'h1000,3,0);
        add(1,0,1,32'h1040,3, 0,32'h40,  32'h1080,3,0);
        add(1,0,1,32'h1080,3, 0,32'h40,  32'h10C0,3,1);
        add(1,0,1,32'h10C0,3, 1,32'h40,  32'h1100,3,2);
        add(1,0,1,32'h9000,5, 1,32'h40,  32'h1100,3,2);
        add(1,0,1,32'h2000,3, 1,32'h40,  32'h2040,3,1);
        add(1,0,1,32'h3000,3, 1,32'h40,  32'h3040,3,0);
        add(1,0,1,32'h5000,3, 0,32'h2000,32'h7000,3,0);
        add(1,0,1,32'h7000,3, 0,32'h2000,32'h9000,3,1);
        add(1,0,1,32'h9000,3, 1,32'h2000,32'hB000,3,2);
        add(0,0,1,32'hB000,3, 1,32'h2000,32'hB000,3,2);
        add(1,0,1,32'hB000,3, 1,32'h2000,32'hD000,3,3);
        add(1,0,1,32'hD000,3, 1,32'h2000,32'hF000,3,3);
        add(1,1,1,32'hF000,3, 0,32'h0,   32'h0,   0,0);
        add(1,0,1,32'h4000,6, 0,32'h0,   32'h4000,6,0);
        add(1,0,1,32'h4000,6, 0,32'h0,   32'h4000,6,0);
        add(0,1,1,32'h4040,6, 0,32'h0,   32'h0,   0,0);
        // Address wrap through zero.
        add(1,0,1,32'hFFFFFF80,2, 0,32'h0, 32'hFFFFFF80,2,0);
        add(1,0,1,32'hFFFFFFC0,2, 0,32'h40,32'h0,       2,0);
        add(1,0,1,32'h00000000,2, 0,32'h40,32'h40,      2,1);
        add(1,0,1,32'h00000040,2, 1,32'h40,32'h80,      2,2);
        add(1,1,0,32'h0,0,        0,32'h0, 32'h0,       0,0);
        // Training restarts and stride replacement.
        add(1,0,1,32'h100,4, 0,32'h0, 32'h100,4,0);
        add(1,0,1,32'h140,4, 0,32'h40,32'h180,4,0);
        add(1,0,1,32'h180,4, 0,32'h40,32'h1C0,4,1);
        add(1,0,1,32'h180,4, 0,32'h0, 32'h180,4,0);
        add(1,0,1,32'h200,4, 0,32'h80,32'h280,4,0);
        add(1,0,1,32'h240,4, 0,32'h40,32'h280,4,0);
        add(1,0,1,32'h280,4, 0,32'h40,32'h2C0,4,1);
        add(1,1,0,32'h0,0,   0,32'h0, 32'h0,  0,0);
        // Descending stream.
        add(1,0,1,32'h1100,1, 0,32'h0,32'h1100,1,0);
`ifdef STRIDE_NEG_STRIDE_EN
        add(1,0,1,32'h10C0,1, 0,32'hFFFFFFC0,32'h1080,1,0);
        add(1,0,1,32'h1080,1, 0,32'hFFFFFFC0,32'h1040,1,1);
        add(1,0,1,32'h1040,1, 1,32'hFFFFFFC0,32'h1000,1,2);
`else
        add(1,0,1,32'h10C0,1, 0,32'h0,32'h10C0,1,0);
        add(1,0,1,32'h1080,1, 0,32'h0,32'h1080,1,0);
        add(1,0,1,32'h1040,1, 0,32'h0,32'h1040,1,0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_hold", 0, 32'h0, 32'h0, 4'h0, 2'h0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        chk_all("reset_idle", 0, 32'h0, 32'h0, 4'h0, 2'h0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].v, tbl[i].addr, tbl[i].id);
            chk_all($sformatf("vec%0d", i), tbl[i].sv, tbl[i].stride,
                    tbl[i].pred, tbl[i].tid, tbl[i].conf);
        end

        // Asynchronous reset in the middle of a locked stream, away from any clock edge.
        drive(1,1,0,32'h0,0);
        drive(1,0,1,32'hA000,7);
        drive(1,0,1,32'hA010,7);
        drive(1,0,1,32'hA020,7);
        drive(1,0,1,32'hA030,7);
        chk_all("pre_async", 1, 32'h10, 32'hA040, 4'h7, 2'h2);
        @(negedge clk);
        bus.obs_valid = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        chk_all("async_rst", 0, 32'h0, 32'h0, 4'h0, 2'h0);
        @(negedge clk);
        resetN = 1'b1;

        // Random multi-stream traffic against the model.
        m_clear();
        step[0] = 32'h40; step[1] = 32'h100; step[2] = 32'hFFFFFF80;
        base[0] = 32'h0001_0000; base[1] = 32'h0800_0000; base[2] = 32'h4000_0000;
        for (int c = 0; c < 600; c++) begin
            f  = (c == 0) || ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 3) != 0);
            id = 4'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = base[id] + step[id];
                6, 7:             a = base[id] + (32'($urandom_range(0, 8)) << 4) - 32'h40;
                default:          a = $urandom;
            endcase
            if (e && v) base[id] = a;
            drive(e, f, v, a, id);
            m_apply(e, f, v, a, id);
            chk_all($sformatf("rnd%0d", c), m_stage == 3, m_stride,
                    m_last + m_stride, m_tid, 2'(m_conf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
